// File: rtl/adam_spi_pkg.sv
// adam_spi_pkg: shared SPI types and widths.
//   spi_state_e : PHY engine states (also used by the adam_periph_spi register block)
//   DLEN_W      : width of the frame-length field
//   EDGE_W      : width of the sclk edge index (holds 2*DATA_WIDTH+1 for DATA_WIDTH <= 64)
package adam_spi_pkg;

  localparam int unsigned DLEN_W = 6;
  localparam int unsigned EDGE_W = DLEN_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_PAUSED
  } spi_state_e;

endpackage

// File: rtl/adam_spi_phy_if.sv
// adam_spi_phy_if: frame-level transmit/receive bus of the SPI PHY.
//   tx_data/tx_valid/tx_ready : valid/ready frame handshake into the PHY
//   rx_data/rx_valid          : received frame, rx_valid is a one-cycle pulse
//   master modport: the client feeding frames; slave modport: the PHY.
interface adam_spi_phy_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/adam_spi_clkgen.sv
// adam_spi_clkgen: sclk half-period timer for the SPI PHY.
//   clk, rst  : system clock, synchronous active-high reset
//   start     : frame handshake; latches H = max(1, brr/2) and arms the timer
//   run       : frame in progress (LEAD/SHIFT/TRAIL)
//   brr       : clk cycles per sclk period
//   tick      : an sclk edge (or the end of TRAIL) happens at this clk edge
//   edge_num  : 1-based index of the edge signalled by tick
module adam_spi_clkgen
  import adam_spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] brr,
  output logic                  tick,
  output logic [EDGE_W-1:0]     edge_num
);

  logic [DATA_WIDTH-1:0] half;
  logic [DATA_WIDTH-1:0] half_q;
  logic [DATA_WIDTH-1:0] cnt_q;
  logic [EDGE_W-1:0]     edges_q;

  always_comb begin
    half = {1'b0, brr[DATA_WIDTH-1:1]};
    if (half == '0) half = DATA_WIDTH'(1);
  end

  assign tick     = run && (cnt_q == '0);
  assign edge_num = edges_q + EDGE_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      half_q  <= '0;
      cnt_q   <= '0;
      edges_q <= '0;
    end else if (start) begin
      half_q  <= half;
      cnt_q   <= half - DATA_WIDTH'(1);
      edges_q <= '0;
    end else if (run) begin
      if (cnt_q == '0) begin
        cnt_q   <= half_q - DATA_WIDTH'(1);
        edges_q <= edges_q + EDGE_W'(1);
      end else begin
        cnt_q <= cnt_q - DATA_WIDTH'(1);
      end
    end else begin
      cnt_q   <= '0;
      edges_q <= '0;
    end
  end

endmodule

// File: rtl/adam_spi_phy.sv
// adam_spi_phy: SPI master PHY, one frame of 1..DATA_WIDTH bits per handshake.
//   clk, rst            : system clock, synchronous active-high reset
//   pause_req/pause_ack : pause handshake, honoured only between frames
//   en                  : engine enable; dropping it aborts a frame in flight
//   cpol/cpha/lsbf/dlen : SPI mode, bit order, frame length (0 or >DATA_WIDTH = DATA_WIDTH)
//   brr                 : clk cycles per sclk period
//   bus                 : frame handshake (tx) and received frame (rx)
//   busy                : engine not in IDLE
//   sclk_o/mosi_o/ss_n_o/miso_i : serial pins
// Frame timeline after a handshake at T: ss_n_o low at T+1, LEAD for H cycles,
// 2*n sclk edges spaced H apart, TRAIL for H cycles, then rx_valid.
module adam_spi_phy
  import adam_spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause_req,
  output logic                  pause_ack,
  input  logic                  en,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsbf,
  input  logic [DLEN_W-1:0]     dlen,
  input  logic [DATA_WIDTH-1:0] brr,
  adam_spi_phy_if.slave         bus,
  output logic                  busy,
  output logic                  sclk_o,
  output logic                  mosi_o,
  output logic                  ss_n_o,
  input  logic                  miso_i
);

  spi_state_e state_q, state_d;

  logic                  cpol_q, cpha_q, lsbf_q;
  logic [EDGE_W-1:0]     nbits_q;
  logic [EDGE_W-1:0]     n_in;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_data_q;
  logic                  sclk_q, ss_n_q, rx_valid_q;

  logic                  hs, frame, abort, tick;
  logic [EDGE_W-1:0]     edge_num;
  logic                  odd_edge, sample_edge, shift_edge, last_edge;

  assign bus.tx_ready = (state_q == ST_IDLE) && en && !pause_req && !rst;
  assign hs           = bus.tx_valid && bus.tx_ready;
  assign frame        = (state_q == ST_LEAD) || (state_q == ST_SHIFT) || (state_q == ST_TRAIL);
  assign abort        = frame && !en;

  always_comb begin
    n_in = EDGE_W'(dlen);
    if (dlen == '0 || n_in > EDGE_W'(DATA_WIDTH)) n_in = EDGE_W'(DATA_WIDTH);
  end

  adam_spi_clkgen #(.DATA_WIDTH(DATA_WIDTH)) u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .start    (hs),
    .run      (frame),
    .brr      (brr),
    .tick     (tick),
    .edge_num (edge_num)
  );

  // Edge 1 already carries the first bit for cpha=1 (it was driven from T+1),
  // so the leading-edge shift is skipped for that edge only.
  assign odd_edge    = edge_num[0];
  assign sample_edge = cpha_q ? !odd_edge : odd_edge;
  assign shift_edge  = cpha_q ? (odd_edge && edge_num != EDGE_W'(1)) : !odd_edge;
  assign last_edge   = (edge_num == {nbits_q[EDGE_W-2:0], 1'b0});

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pause_req) state_d = ST_PAUSED;
        else if (hs)   state_d = ST_LEAD;
      end
      ST_LEAD: begin
        if (!en)       state_d = ST_IDLE;
        else if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!en)                    state_d = ST_IDLE;
        else if (tick && last_edge) state_d = ST_TRAIL;
      end
      ST_TRAIL: begin
        if (!en || tick) state_d = ST_IDLE;
      end
      ST_PAUSED: begin
        if (!pause_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsbf_q     <= 1'b0;
      nbits_q    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (hs) begin
        cpol_q  <= cpol;
        cpha_q  <= cpha;
        lsbf_q  <= lsbf;
        nbits_q <= n_in;
        // MSB-first frames are left-aligned so the outgoing bit is always the top bit.
        tx_sr   <= lsbf ? bus.tx_data : (bus.tx_data << (DATA_WIDTH - 32'(n_in)));
        rx_sr   <= '0;
        ss_n_q  <= 1'b0;
        sclk_q  <= cpol;
      end else if (abort) begin
        ss_n_q <= 1'b1;
        sclk_q <= cpol_q;
      end else if (frame && tick) begin
        if (state_q == ST_TRAIL) begin
          ss_n_q     <= 1'b1;
          rx_valid_q <= 1'b1;
          // LSB-first frames assemble from the top down; right-align on completion.
          rx_data_q  <= lsbf_q ? (rx_sr >> (DATA_WIDTH - 32'(nbits_q))) : rx_sr;
        end else begin
          sclk_q <= ~sclk_q;
          if (sample_edge)
            rx_sr <= lsbf_q ? {miso_i, rx_sr[DATA_WIDTH-1:1]} : {rx_sr[DATA_WIDTH-2:0], miso_i};
          if (shift_edge)
            tx_sr <= lsbf_q ? (tx_sr >> 1) : (tx_sr << 1);
        end
      end
    end
  end

  assign mosi_o       = lsbf_q ? tx_sr[0] : tx_sr[DATA_WIDTH-1];
  assign sclk_o       = sclk_q;
  assign ss_n_o       = ss_n_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign busy         = (state_q != ST_IDLE);
  assign pause_ack    = (state_q == ST_PAUSED);

endmodule

// File: tb/tb_adam_spi_phy.sv
module tb_adam_spi_phy;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pause_req = 1'b0;
  logic          pause_ack;
  logic          en = 1'b0;
  logic          cpol = 1'b0, cpha = 1'b0, lsbf = 1'b0;
  logic [5:0]    dlen = '0;
  logic [DW-1:0] brr = '0;
  logic          busy, sclk_o, mosi_o, ss_n_o, miso_i;
  logic          loop_en = 1'b1;
  logic          slv_bit = 1'b0;

  int n_checks = 0;
  int n_errs   = 0;

  adam_spi_phy_if #(.DATA_WIDTH(DW)) bus ();

  adam_spi_phy #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .pause_req (pause_req),
    .pause_ack (pause_ack),
    .en        (en),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsbf      (lsbf),
    .dlen      (dlen),
    .brr       (brr),
    .bus       (bus),
    .busy      (busy),
    .sclk_o    (sclk_o),
    .mosi_o    (mosi_o),
    .ss_n_o    (ss_n_o),
    .miso_i    (miso_i)
  );

  // Either loopback or a behavioural slave shifting out its own word.
  assign miso_i = loop_en ? mosi_o : slv_bit;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned eff_len(input logic [5:0] d);
    return (d == 0 || d > DW) ? DW : int'(d);
  endfunction

  function automatic int unsigned half_of(input logic [31:0] b);
    return (b / 2 == 0) ? 1 : b / 2;
  endfunction

  function automatic int unsigned bit_pos(input int unsigned s, input int unsigned n, input logic lsb);
    return lsb ? s : n - 1 - s;
  endfunction

  function automatic logic [31:0] mask_of(input int unsigned n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, "/sclk"},     32'(sclk_o),       32'd0);
    check_eq({tag, "/ss_n"},     32'(ss_n_o),       32'd1);
    check_eq({tag, "/mosi"},     32'(mosi_o),       32'd0);
    check_eq({tag, "/tx_ready"}, 32'(bus.tx_ready), 32'd0);
    check_eq({tag, "/rx_valid"}, 32'(bus.rx_valid), 32'd0);
    check_eq({tag, "/rx_data"},  bus.rx_data,       32'd0);
    check_eq({tag, "/busy"},     32'(busy),         32'd0);
    check_eq({tag, "/pause_ack"},32'(pause_ack),    32'd0);
  endtask

  // kind: 0 plain frame, 1 drop en after edge at_edge, 2 pulse rst after edge at_edge,
  //       3 raise pause_req after edge at_edge and let the frame finish.
  task automatic run_frame(input string tag, input logic [31:0] data, input logic [5:0] dl,
                           input logic [31:0] br, input logic pol, input logic pha,
                           input logic lsb, input logic loop, input logic [31:0] slv,
                           input int kind, input int unsigned at_edge);
    int unsigned n, h, low, edges, s, pulses;
    logic        prev;
    logic [31:0] got_tx, exp_rx;
    bit          done;
    n      = eff_len(dl);
    h      = half_of(br);
    s      = 0;
    got_tx = '0;
    exp_rx = (loop ? data : slv) & mask_of(n);

    @(negedge clk);
    loop_en      = loop;
    slv_bit      = slv[bit_pos(0, n, lsb)];
    cpol         = pol;
    cpha         = pha;
    lsbf         = lsb;
    dlen         = dl;
    brr          = br;
    bus.tx_data  = data;
    bus.tx_valid = 1'b1;
    check_eq({tag, "/ready"}, 32'(bus.tx_ready), 32'd1);

    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    // Config is scrambled after the handshake; the frame must not notice.
    cpol        = 1'($urandom);
    cpha        = 1'($urandom);
    lsbf        = 1'($urandom);
    dlen        = 6'($urandom);
    brr         = $urandom_range(0, 9);
    bus.tx_data = $urandom;
    check_eq({tag, "/ss_n_T+1"},  32'(ss_n_o), 32'd0);
    check_eq({tag, "/sclk_idle"}, 32'(sclk_o), 32'(pol));
    check_eq({tag, "/mosi_first"},32'(mosi_o), 32'(data[bit_pos(0, n, lsb)]));

    prev  = pol;
    low   = 1;
    edges = 0;
    done  = 0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(posedge clk); #1;
      if (ss_n_o) begin
        done = 1;
      end else begin
        low++;
        if (sclk_o !== prev) begin
          edges++;
          prev = sclk_o;
          if ((edges % 2 == 1) != (pha == 1'b1)) begin
            if (s < n) got_tx[bit_pos(s, n, lsb)] = mosi_o;
            s++;
            if (s < n) slv_bit = slv[bit_pos(s, n, lsb)];
          end
          if (kind != 0 && edges == at_edge) begin
            if (kind == 1) begin
              en = 1'b0;
              @(posedge clk); #1;
              check_eq({tag, "/abort_ss_n"}, 32'(ss_n_o), 32'd1);
              check_eq({tag, "/abort_sclk"}, 32'(sclk_o), 32'(pol));
              check_eq({tag, "/abort_busy"}, 32'(busy),   32'd0);
              pulses = 0;
              for (int k = 0; k < int'(4 * h + 4); k++) begin
                if (bus.rx_valid) pulses++;
                @(posedge clk); #1;
              end
              check_eq({tag, "/abort_no_rx"}, pulses, 32'd0);
              en = 1'b1;
              #1;
              check_eq({tag, "/abort_ready"}, 32'(bus.tx_ready), 32'd1);
              return;
            end else if (kind == 2) begin
              rst = 1'b1;
              @(posedge clk); #1;
              check_reset_values({tag, "/midrst"});
              rst = 1'b0;
              return;
            end else begin
              pause_req = 1'b1;
            end
          end
        end
      end
    end

    if (!done) begin
      check_eq({tag, "/timeout"}, 32'd0, 32'd1);
      return;
    end
    check_eq({tag, "/rx_valid"}, 32'(bus.rx_valid), 32'd1);
    check_eq({tag, "/rx_data"},  bus.rx_data,       exp_rx);
    check_eq({tag, "/ss_low"},   low,               (2 * n + 1) * h);
    check_eq({tag, "/edges"},    edges,             2 * n);
    check_eq({tag, "/sclk_end"}, 32'(sclk_o),       32'(pol));
    check_eq({tag, "/mosi_bits"},got_tx,            data & mask_of(n));
    if (kind == 3) begin
      check_eq({tag, "/ack_late"},   32'(pause_ack),    32'd0);
      check_eq({tag, "/ready_paused"},32'(bus.tx_ready),32'd0);
    end
  endtask

  initial begin
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    en  = 1'b1;

    run_frame("mode0_a5", 32'hA5, 6'd8, 32'd50, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("rx_hold", bus.rx_data, 32'hA5);

    run_frame("mode3_3c", 32'h3C, 6'd8, 32'd10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 0, 0);
    run_frame("full_dead", 32'hDEADBEEF, 6'd0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 0, 0);
    run_frame("brr0", 32'h1234_5678, 6'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 0, 0);
    run_frame("slave_m1", 32'h0F0F, 6'd13, 32'd7, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1ABC, 0, 0);

    run_frame("abort", 32'h5A, 6'd8, 32'd6, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1, 5);

    run_frame("pause", 32'h9, 6'd4, 32'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h6, 3, 3);
    @(posedge clk); #1;
    check_eq("pause_ack_on",   32'(pause_ack),    32'd1);
    check_eq("pause_ready",    32'(bus.tx_ready), 32'd0);
    check_eq("pause_busy",     32'(busy),         32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("pause_hold",     32'(pause_ack),    32'd1);
    pause_req = 1'b0;
    @(posedge clk); #1;
    check_eq("pause_ack_off",  32'(pause_ack),    32'd0);
    check_eq("pause_idle",     32'(busy),         32'd0);
    run_frame("after_pause", 32'h77, 6'd8, 32'd3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      run_frame($sformatf("rand%0d", i), $urandom, 6'($urandom_range(0, 40)),
                $urandom_range(0, 9), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), $urandom, 0, 0);
    end

    run_frame("midrst", 32'hFFFF, 6'd16, 32'd4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 2, 7);
    run_frame("post_rst", 32'h2B, 6'd6, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h15, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
